// File: rtl/trigger_hit_scheduler_pkg.sv
// trigger_pkg: shared constants and types for the trigger hit scheduler.
//   DEF_*        default geometry (channels, ID width, hit limit, counter width)
//   ch_id_t      channel ID (zero-extended index)
//   hit_mask_t   per-channel hit mask, bit i = channel i
//   pop_t        population class of a mask: zero, exactly one, many
//   ST_*         scheduler state encoding
package trigger_pkg;

   localparam int DEF_NUM_CH   = 128;
   localparam int DEF_ID_W     = 9;
   localparam int DEF_MAX_HITS = 32;
   localparam int DEF_CNT_W    = 8;

   typedef logic [DEF_ID_W-1:0]   ch_id_t;
   typedef logic [DEF_NUM_CH-1:0] hit_mask_t;

   typedef enum logic [1:0] {
      POP_ZERO = 2'd0,
      POP_ONE  = 2'd1,
      POP_MANY = 2'd2
   } pop_t;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SERVE = 1'b1;

endpackage

// File: rtl/trigger_hit_scheduler_if.sv
// trigger_hit_scheduler_if: mask input side, channel-ID output side and
// event status of the scheduler.
//   slave  modport: the scheduler itself
//   master modport: the surrounding logic (capture + packer)
interface trigger_hit_scheduler_if
   import trigger_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int ID_W   = DEF_ID_W,
   parameter int CNT_W  = DEF_CNT_W
);

   logic              mask_valid;
   logic              mask_ready;
   logic [NUM_CH-1:0] hit_mask;
   logic              abort;
   logic              ch_valid;
   logic              ch_ready;
   logic [ID_W-1:0]   ch_id;
   logic              ch_last;
   logic              evt_empty;
   logic              evt_trunc;
   logic [CNT_W-1:0]  hit_count;
   logic              busy;

   modport slave (
      input  mask_valid, hit_mask, abort, ch_ready,
      output mask_ready, ch_valid, ch_id, ch_last,
             evt_empty, evt_trunc, hit_count, busy
   );

   modport master (
      output mask_valid, hit_mask, abort, ch_ready,
      input  mask_ready, ch_valid, ch_id, ch_last,
             evt_empty, evt_trunc, hit_count, busy
   );

endinterface

// File: rtl/trigger_hit_scheduler_lowest_set_finder.sv
// lowest_set_finder: combinational lowest-set-bit encoder.
//   vec  in   NUM_CH-bit vector
//   idx  out  index of the lowest set bit (0 when vec is zero)
//   pop  out  POP_ZERO / POP_ONE / POP_MANY population class of vec
module lowest_set_finder
   import trigger_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int ID_W   = DEF_ID_W
)
(
   input  logic [NUM_CH-1:0] vec,
   output logic [ID_W-1:0]   idx,
   output pop_t              pop
);

   logic [NUM_CH-1:0] vec_dec_s;
   logic              any_s;
   logic              multi_s;

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      idx = {ID_W{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = vec[i] ? ID_W'(i) : idx;
      end
   end

   // vec & (vec-1) clears the lowest set bit; anything left means 2+ bits.
   always_comb begin
      vec_dec_s = vec - NUM_CH'(1'b1);
      any_s     = |vec;
      multi_s   = |(vec & vec_dec_s);
   end

   // Classify the population of the vector.
   always_comb begin
      if (!any_s) begin
         pop = POP_ZERO;
      end else if (multi_s) begin
         pop = POP_MANY;
      end else begin
         pop = POP_ONE;
      end
   end

endmodule

// File: rtl/trigger_hit_scheduler.sv
// trigger_hit_scheduler: turns one hit mask per event into an ordered
// stream of channel IDs (lowest first, one per cycle), truncated after
// MAX_HITS IDs.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport: mask_valid/mask_ready/hit_mask, abort,
//        ch_valid/ch_ready/ch_id/ch_last, evt_empty, evt_trunc,
//        hit_count, busy (all outputs registered)
module trigger_hit_scheduler
   import trigger_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int ID_W     = DEF_ID_W,
   parameter int MAX_HITS = DEF_MAX_HITS,
   parameter int CNT_W    = DEF_CNT_W
)
(
   input  logic                  clk,
   input  logic                  rst,
   trigger_hit_scheduler_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HITS - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   logic [0:0]        state_r;
   logic [NUM_CH-1:0] pending_r;
   logic              ch_valid_r;
   logic [ID_W-1:0]   ch_id_r;
   logic              ch_last_r;
   logic              evt_empty_r;
   logic              evt_trunc_r;
   logic [CNT_W-1:0]  hit_count_r;
   logic              mask_ready_r;
   logic              busy_r;

   logic [NUM_CH-1:0] served_s;
   logic [NUM_CH-1:0] advance_s;
   logic [ID_W-1:0]   load_idx_s;
   pop_t              load_pop_s;
   logic [ID_W-1:0]   adv_idx_s;
   pop_t              adv_pop_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              hs_s;
   logic              load_last_s;
   logic              adv_last_s;

   // One-hot of the ID currently on offer; removing it gives the next pending set.
   always_comb begin
      served_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         served_s[i] = (ch_id_r == ID_W'(i));
      end
      advance_s = pending_r & ~served_s;
   end

   lowest_set_finder #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_load_finder (
      .vec (bus.hit_mask),
      .idx (load_idx_s),
      .pop (load_pop_s)
   );

   lowest_set_finder #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_adv_finder (
      .vec (advance_s),
      .idx (adv_idx_s),
      .pop (adv_pop_s)
   );

   // Saturating counter increment and last-ID decisions for load and advance.
   always_comb begin
      hs_s = ch_valid_r & bus.ch_ready;
      if (hit_count_r == CNT_SAT) begin
         cnt_inc_s = hit_count_r;
      end else begin
         cnt_inc_s = hit_count_r + CNT_W'(1'b1);
      end
      // The first ID sits at count 0, so a limit of one hit ends immediately.
      load_last_s = (load_pop_s == POP_ONE) || (LAST_CNT == {CNT_W{1'b0}});
      adv_last_s  = (adv_pop_s == POP_ONE) || (cnt_inc_s == LAST_CNT);
   end

   // Event state machine; abort overrides everything, including a mask offer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         pending_r    <= {NUM_CH{1'b0}};
         ch_valid_r   <= 1'b0;
         ch_id_r      <= {ID_W{1'b0}};
         ch_last_r    <= 1'b0;
         evt_empty_r  <= 1'b0;
         evt_trunc_r  <= 1'b0;
         hit_count_r  <= {CNT_W{1'b0}};
         mask_ready_r <= 1'b1;
         busy_r       <= 1'b0;
      end else begin
         evt_empty_r <= 1'b0;
         evt_trunc_r <= 1'b0;
         if (bus.abort) begin
            state_r      <= ST_IDLE;
            pending_r    <= {NUM_CH{1'b0}};
            ch_valid_r   <= 1'b0;
            ch_last_r    <= 1'b0;
            mask_ready_r <= 1'b1;
            busy_r       <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (bus.mask_valid) begin
                     if (load_pop_s != POP_ZERO) begin
                        state_r      <= ST_SERVE;
                        pending_r    <= bus.hit_mask;
                        hit_count_r  <= {CNT_W{1'b0}};
                        ch_valid_r   <= 1'b1;
                        ch_id_r      <= load_idx_s;
                        ch_last_r    <= load_last_s;
                        mask_ready_r <= 1'b0;
                        busy_r       <= 1'b1;
                     end else begin
                        evt_empty_r <= 1'b1;
                        hit_count_r <= {CNT_W{1'b0}};
                     end
                  end
               end
               ST_SERVE: begin
                  if (hs_s) begin
                     hit_count_r <= cnt_inc_s;
                     if (ch_last_r) begin
                        state_r      <= ST_IDLE;
                        pending_r    <= {NUM_CH{1'b0}};
                        ch_valid_r   <= 1'b0;
                        ch_last_r    <= 1'b0;
                        mask_ready_r <= 1'b1;
                        busy_r       <= 1'b0;
                        // Bits still pending after the final ID were cut by the limit.
                        evt_trunc_r  <= (adv_pop_s != POP_ZERO);
                     end else begin
                        pending_r <= advance_s;
                        ch_id_r   <= adv_idx_s;
                        ch_last_r <= adv_last_s;
                     end
                  end
               end
               default: begin
                  state_r      <= ST_IDLE;
                  pending_r    <= {NUM_CH{1'b0}};
                  ch_valid_r   <= 1'b0;
                  ch_last_r    <= 1'b0;
                  mask_ready_r <= 1'b1;
                  busy_r       <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.mask_ready = mask_ready_r;
   assign bus.ch_valid   = ch_valid_r;
   assign bus.ch_id      = ch_id_r;
   assign bus.ch_last    = ch_last_r;
   assign bus.evt_empty  = evt_empty_r;
   assign bus.evt_trunc  = evt_trunc_r;
   assign bus.hit_count  = hit_count_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_trigger_hit_scheduler.sv
// tb_trigger_hit_scheduler: directed bench for trigger_hit_scheduler with
// hand-computed expectations. Inputs change 1 time unit after each rising
// edge; outputs are sampled at the same point.
module tb_trigger_hit_scheduler;
   import trigger_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   hit_mask_t m;

   trigger_hit_scheduler_if bus ();

   trigger_hit_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.mask_valid = 1'b0;
      bus.hit_mask   = {DEF_NUM_CH{1'b0}};
      bus.abort      = 1'b0;
      bus.ch_ready   = 1'b0;

      // Reset values
      #2 rst = 1'b1;
      #2;
      chk("rst_ch_valid",   bus.ch_valid,   0);
      chk("rst_mask_ready", bus.mask_ready, 1);
      chk("rst_busy",       bus.busy,       0);
      chk("rst_ch_id",      bus.ch_id,      0);
      chk("rst_ch_last",    bus.ch_last,    0);
      chk("rst_hit_count",  bus.hit_count,  0);
      chk("rst_evt_empty",  bus.evt_empty,  0);
      chk("rst_evt_trunc",  bus.evt_trunc,  0);
      tick();
      rst = 1'b0;

      // Channels 3, 10, 127 with ch_ready held high
      m = {DEF_NUM_CH{1'b0}};
      m[3] = 1'b1; m[10] = 1'b1; m[127] = 1'b1;
      bus.hit_mask = m; bus.mask_valid = 1'b1; bus.ch_ready = 1'b1;
      tick();
      bus.mask_valid = 1'b0;
      chk("t1_valid0", bus.ch_valid, 1);
      chk("t1_id0",    bus.ch_id,    3);
      chk("t1_last0",  bus.ch_last,  0);
      chk("t1_mrdy0",  bus.mask_ready, 0);
      chk("t1_busy0",  bus.busy,     1);
      chk("t1_cnt0",   bus.hit_count, 0);
      tick();
      chk("t1_id1",    bus.ch_id,    10);
      chk("t1_last1",  bus.ch_last,  0);
      chk("t1_cnt1",   bus.hit_count, 1);
      tick();
      chk("t1_id2",    bus.ch_id,    127);
      chk("t1_last2",  bus.ch_last,  1);
      tick();
      chk("t1_valid_end", bus.ch_valid, 0);
      chk("t1_cnt_end",   bus.hit_count, 3);
      chk("t1_mrdy_end",  bus.mask_ready, 1);
      chk("t1_trunc_end", bus.evt_trunc, 0);
      chk("t1_busy_end",  bus.busy, 0);

      // Empty mask
      bus.hit_mask = {DEF_NUM_CH{1'b0}}; bus.mask_valid = 1'b1;
      tick();
      bus.mask_valid = 1'b0;
      chk("t2_empty",  bus.evt_empty, 1);
      chk("t2_valid",  bus.ch_valid,  0);
      chk("t2_mrdy",   bus.mask_ready, 1);
      tick();
      chk("t2_empty_drop", bus.evt_empty, 0);
      chk("t2_valid2",     bus.ch_valid,  0);

      // All ones, truncated to 32 IDs
      bus.hit_mask = {DEF_NUM_CH{1'b1}}; bus.mask_valid = 1'b1; bus.ch_ready = 1'b1;
      tick();
      bus.mask_valid = 1'b0;
      for (int k = 0; k < 32; k++) begin
         chk($sformatf("t3_valid%0d", k), bus.ch_valid, 1);
         chk($sformatf("t3_id%0d", k),    bus.ch_id, k);
         chk($sformatf("t3_last%0d", k),  bus.ch_last, (k == 31) ? 1 : 0);
         tick();
      end
      chk("t3_valid_end", bus.ch_valid, 0);
      chk("t3_trunc",     bus.evt_trunc, 1);
      chk("t3_cnt",       bus.hit_count, 32);
      tick();
      chk("t3_trunc_drop", bus.evt_trunc, 0);

      // Channels 5, 6 with backpressure
      m = {DEF_NUM_CH{1'b0}};
      m[5] = 1'b1; m[6] = 1'b1;
      bus.hit_mask = m; bus.mask_valid = 1'b1; bus.ch_ready = 1'b0;
      tick();
      bus.mask_valid = 1'b0;
      chk("t4_id_a",   bus.ch_id, 5);
      chk("t4_valid_a", bus.ch_valid, 1);
      tick();
      chk("t4_id_hold",   bus.ch_id, 5);
      chk("t4_last_hold", bus.ch_last, 0);
      chk("t4_cnt_hold",  bus.hit_count, 0);
      bus.ch_ready = 1'b1;
      tick();
      bus.ch_ready = 1'b0;
      chk("t4_id_b",   bus.ch_id, 6);
      chk("t4_last_b", bus.ch_last, 1);
      chk("t4_cnt_b",  bus.hit_count, 1);
      tick();
      chk("t4_id_b_hold",    bus.ch_id, 6);
      chk("t4_valid_b_hold", bus.ch_valid, 1);
      bus.ch_ready = 1'b1;
      tick();
      chk("t4_valid_end", bus.ch_valid, 0);
      chk("t4_cnt_end",   bus.hit_count, 2);
      chk("t4_trunc_end", bus.evt_trunc, 0);

      // Abort after first handshake of channels 1, 2, 3
      m = {DEF_NUM_CH{1'b0}};
      m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1;
      bus.hit_mask = m; bus.mask_valid = 1'b1; bus.ch_ready = 1'b1;
      tick();
      bus.mask_valid = 1'b0;
      chk("t5_id0", bus.ch_id, 1);
      tick();
      chk("t5_id1", bus.ch_id, 2);
      bus.ch_ready = 1'b0; bus.abort = 1'b1;
      tick();
      chk("t5_valid", bus.ch_valid, 0);
      chk("t5_mrdy",  bus.mask_ready, 1);
      chk("t5_trunc", bus.evt_trunc, 0);
      chk("t5_busy",  bus.busy, 0);
      chk("t5_cnt",   bus.hit_count, 1);
      // A mask offered together with abort is ignored
      m = {DEF_NUM_CH{1'b0}};
      m[0] = 1'b1;
      bus.hit_mask = m; bus.mask_valid = 1'b1;
      tick();
      chk("t5_ign_valid", bus.ch_valid, 0);
      chk("t5_ign_mrdy",  bus.mask_ready, 1);
      chk("t5_ign_empty", bus.evt_empty, 0);
      bus.abort = 1'b0; bus.ch_ready = 1'b1;
      tick();
      bus.mask_valid = 1'b0;
      chk("t5_new_valid", bus.ch_valid, 1);
      chk("t5_new_id",    bus.ch_id, 0);
      chk("t5_new_last",  bus.ch_last, 1);
      tick();
      chk("t5_new_end", bus.ch_valid, 0);
      chk("t5_new_cnt", bus.hit_count, 1);

      // Asynchronous reset in the middle of an event
      m = {DEF_NUM_CH{1'b0}};
      m[3] = 1'b1; m[10] = 1'b1; m[127] = 1'b1;
      bus.hit_mask = m; bus.mask_valid = 1'b1; bus.ch_ready = 1'b0;
      tick();
      bus.mask_valid = 1'b0;
      chk("t6_busy_pre",  bus.busy, 1);
      chk("t6_valid_pre", bus.ch_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_valid_rst", bus.ch_valid, 0);
      chk("t6_busy_rst",  bus.busy, 0);
      chk("t6_mrdy_rst",  bus.mask_ready, 1);
      chk("t6_id_rst",    bus.ch_id, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_mrdy_post",  bus.mask_ready, 1);
      chk("t6_valid_post", bus.ch_valid, 0);
      m = {DEF_NUM_CH{1'b0}};
      m[64] = 1'b1;
      bus.hit_mask = m; bus.mask_valid = 1'b1; bus.ch_ready = 1'b1;
      tick();
      bus.mask_valid = 1'b0;
      chk("t6_id_after",   bus.ch_id, 64);
      chk("t6_last_after", bus.ch_last, 1);
      tick();
      chk("t6_end_valid", bus.ch_valid, 0);
      chk("t6_end_cnt",   bus.hit_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trigger_hit_scheduler.md
Name: trigger_hit_scheduler

Overview:
- Accepts one 128-bit per-channel hit mask per trigger event.
- Serialises the set channels into a stream of channel IDs, lowest index first, one per cycle, using a valid/ready handshake.
- Sits between the hit-mask capture logic and the trigger-info packer. It replaces the single "first hit only" encoding with a full, ordered, optionally truncated hit list per event.

Parameters:
- NUM_CH, 128, number of hit channels (width of hit_mask).
- ID_W, 9, width of emitted channel ID (zero-extended index).
- MAX_HITS, 32, maximum IDs emitted per event; remaining hits are dropped and flagged.
- CNT_W, 8, width of per-event hit counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mask_valid  in  1  hit_mask is presented for a new event.
- mask_ready  out  1  scheduler can accept a new mask (IDLE only).
- hit_mask  in  NUM_CH  per-channel hit bits, bit i = channel i.
- abort  in  1  synchronous flush of the current event.
- ch_valid  out  1  ch_id is valid.
- ch_ready  in  1  downstream accepts ch_id.
- ch_id  out  ID_W  channel index of current hit.
- ch_last  out  1  qualifies ch_valid: final ID of this event.
- evt_empty  out  1  one-cycle pulse: accepted mask was all-zero.
- evt_trunc  out  1  one-cycle pulse: event ended with hits dropped by MAX_HITS.
- hit_count  out  CNT_W  IDs emitted so far in current/last event.
- busy  out  1  high in SERVE.

Behaviour:
- Reset values: state IDLE, pending 0, mask_ready 1, ch_valid 0, ch_id 0, ch_last 0, evt_empty 0, evt_trunc 0, hit_count 0, busy 0.
- States: IDLE and SERVE.
- IDLE: mask_ready=1.
  - On mask_valid with a nonzero mask: latch pending<=hit_mask, hit_count<=0, register ch_id=lowest set index, ch_valid=1 from the next cycle, go to SERVE. Latency from mask accept to first ch_valid is 1 cycle.
  - On mask_valid with a zero mask: evt_empty=1 for one cycle, stay in IDLE, no ch_valid.
- SERVE: mask_ready=0, busy=1. ch_id/ch_valid/ch_last are registered and held stable while ch_valid && !ch_ready.
- Handshake (ch_valid && ch_ready):
  - Clear the served bit in pending and increment hit_count.
  - If the ID was not last, present the lowest set index of the updated pending on the next cycle. No bubble: a sustained ch_ready gives 1 ID/cycle.
- ch_last is high when either:
  - pending has exactly one bit set (natural end), or
  - hit_count == MAX_HITS-1 (truncation end).
- Handshake on ch_last:
  - Go to IDLE, clear pending, drop ch_valid next cycle.
  - If pending still held other bits, pulse evt_trunc in that same next cycle.
- The earliest new mask accept is the cycle after the last handshake. There is no accept in the same cycle as a last handshake.
- abort: highest priority in any state. Next cycle: IDLE, pending=0, ch_valid=0, no evt_trunc/evt_empty pulse. hit_count holds its value. A mask_valid coincident with abort is ignored (not accepted).
- mask_valid while in SERVE is not accepted. The upstream holds it until mask_ready.
- hit_count saturates at 2^CNT_W-1. CNT_W must cover MAX_HITS.
- ch_id is the channel index zero-extended to ID_W. Bits above clog2(NUM_CH) are always 0.
- Asynchronous rst mid-event: all outputs go to reset values immediately, and the event is lost.

Decomposition:
- Shared package trigger_pkg holds:
  - NUM_CH, ID_W defaults;
  - the channel-ID typedef (ID_W bits);
  - the hit-mask typedef (NUM_CH bits);
  - state encoding constants ST_IDLE, ST_SERVE.
- One sub-module, lowest_set_finder: combinational, NUM_CH-bit input → ID_W-bit index of lowest set bit, plus any/onehot-count (zero, one, many) outputs.
  - The scheduler instantiates it twice: on hit_mask (load path) and on pending-with-served-bit-cleared (advance path).

Test Plan:
- Reset, then mask=bits{3,10,127}, ch_ready=1 constantly → ch_id 3,10,127 on consecutive cycles starting 1 cycle after accept; ch_last only with 127; hit_count=3; mask_ready back the cycle after.
- mask=0 with mask_valid → evt_empty one-cycle pulse, no ch_valid, mask_ready stays 1.
- mask=all-ones, MAX_HITS=32, ch_ready=1 → IDs 0..31, ch_last on 31, evt_trunc pulse next cycle, hit_count=32.
- mask=bits{5,6}, ch_ready toggling 0/1 → ch_id=5 held stable while ch_ready=0; each ID emitted exactly once; no skips.
- abort asserted after the first handshake of mask=bits{1,2,3} → next cycle ch_valid=0, mask_ready=1, no evt_trunc; a new mask bits{0} then yields ch_id=0 with ch_last.
- Async rst asserted mid-SERVE (between clock edges) → ch_valid, busy drop immediately, mask_ready=1 after release.
